// File: rtl/local_pattern_table_pkg.sv
// Shared types and helpers for the local pattern table: default widths, counter
// type, FSM states and the saturating counter step.
package lpt_pkg;

  localparam int HIST_BITS_DEF = 10;
  localparam int CTR_BITS_DEF  = 2;

  typedef logic [CTR_BITS_DEF-1:0] ctr_t;

  // Weakly-not-taken sits just below the taken threshold (2'b01 for 2-bit counters).
  localparam ctr_t WEAK_NT = ctr_t'({1'b0, {(CTR_BITS_DEF-1){1'b1}}});

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  function automatic ctr_t sat_step(ctr_t ctr, logic taken);
    if (taken) begin
      return (ctr == '1) ? ctr : ctr + 1'b1;
    end
    return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/local_pattern_table_if.sv
// Lookup/resolve/prediction bundle between the local history side and the pattern table.
interface local_pattern_table_if
  import lpt_pkg::*;
#(
  parameter int HIST_BITS = HIST_BITS_DEF,
  parameter int CTR_BITS  = CTR_BITS_DEF
);

  logic                 hist_valid;
  logic [HIST_BITS-1:0] hist;
  logic                 resolve_valid;
  logic                 resolve_taken;
  logic                 flush;
  logic                 pred_taken;
  logic [CTR_BITS-1:0]  pred_ctr;
  logic                 ready;

  modport master (
    output hist_valid, hist, resolve_valid, resolve_taken, flush,
    input  pred_taken, pred_ctr, ready
  );

  modport slave (
    input  hist_valid, hist, resolve_valid, resolve_taken, flush,
    output pred_taken, pred_ctr, ready
  );

endinterface

// File: rtl/local_pattern_table_delay_line.sv
// Carries each lookup's {valid, index} forward until its branch outcome arrives.
module lpt_delay_line #(
  parameter int IDX_BITS = 10,
  parameter int DEPTH    = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [IDX_BITS-1:0] in_idx,
  output logic                out_valid,
  output logic [IDX_BITS-1:0] out_idx
);

  logic [DEPTH-1:0]    valid_q;
  logic [IDX_BITS-1:0] idx_q [DEPTH];

  // Valids are cleared outside normal operation and on flush; indices simply ride along.
  always_ff @(posedge clock) begin
    if (!reset || !enable || flush) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
    end
    idx_q[0] <= in_idx;
    for (int k = 1; k < DEPTH; k++) begin
      idx_q[k] <= idx_q[k-1];
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/local_pattern_table.sv
// Local-path pattern table: history-indexed saturating counters with same-cycle
// prediction, delayed training on resolve, and a full-table init walk after reset.
module local_pattern_table
  import lpt_pkg::*;
#(
  parameter int HIST_BITS   = HIST_BITS_DEF,
  parameter int CTR_BITS    = CTR_BITS_DEF,
  parameter int RESOLVE_LAT = 2
) (
  input logic                  clock,
  input logic                  reset,
  local_pattern_table_if.slave bus
);

  localparam int DEPTH = 2 ** HIST_BITS;

  logic [CTR_BITS-1:0]  ctr_table [DEPTH];
  state_t               state;
  logic [HIST_BITS-1:0] init_idx;
  logic                 run;
  logic                 old_valid;
  logic [HIST_BITS-1:0] old_idx;
  logic [CTR_BITS-1:0]  old_ctr;
  logic [CTR_BITS-1:0]  upd_ctr;
  logic                 do_update;

  assign run = (state == RUN);

  lpt_delay_line #(
    .IDX_BITS (HIST_BITS),
    .DEPTH    (RESOLVE_LAT)
  ) u_delay (
    .clock     (clock),
    .reset     (reset),
    .enable    (run),
    .flush     (bus.flush),
    .in_valid  (bus.hist_valid),
    .in_idx    (bus.hist),
    .out_valid (old_valid),
    .out_idx   (old_idx)
  );

  // Counter helpers in lpt_pkg are sized to CTR_BITS_DEF; the casts keep widths explicit.
  assign old_ctr   = ctr_table[old_idx];
  assign upd_ctr   = CTR_BITS'(sat_step(ctr_t'(old_ctr), bus.resolve_taken));
  assign do_update = run && bus.resolve_valid && old_valid;

  assign bus.ready      = run;
  assign bus.pred_ctr   = run ? ctr_table[bus.hist] : '0;
  assign bus.pred_taken = bus.pred_ctr[CTR_BITS-1];

  // Single write port: the init walk and training writes live in disjoint states.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= INIT;
      init_idx <= '0;
    end else begin
      case (state)
        INIT: begin
          ctr_table[init_idx] <= CTR_BITS'(WEAK_NT);
          init_idx            <= init_idx + 1'b1;
          if (init_idx == '1) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (do_update) begin
            ctr_table[old_idx] <= upd_ctr;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_local_pattern_table.sv
// Randomised scoreboard bench for local_pattern_table against a cycle-indexed
// reference model of the counter table and in-flight lookups.
module tb_local_pattern_table;
  import lpt_pkg::*;

  localparam int HB    = 10;
  localparam int CB    = 2;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << HB;
  localparam int CMAX  = (1 << CB) - 1;
  localparam int WEAK  = (1 << (CB - 1)) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;

  local_pattern_table_if #(.HIST_BITS(HB), .CTR_BITS(CB)) bus ();

  local_pattern_table #(
    .HIST_BITS   (HB),
    .CTR_BITS    (CB),
    .RESOLVE_LAT (LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit rdy;
    int ctr;
    int h;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   mtab[DEPTH];
  bit   model_ready = 1'b0;
  int   cyc = 0;
  bit   ent_v[int];
  int   ent_i[int];

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every presented lookup is matched against the oldest queued expectation.
  always @(negedge clock) begin
    if (bus.hist_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 0, 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput($sformatf("ready@%03h", e.h), bus.ready, e.rdy);
        checkOutput($sformatf("pred_ctr@%03h", e.h), bus.pred_ctr, e.ctr);
        checkOutput($sformatf("pred_taken@%03h", e.h), bus.pred_taken, e.ctr >> (CB - 1));
      end
    end
  end

  task automatic applyStimulus(bit hv, int h, bit rv, bit rt, bit fl);
    exp_t e;
    bus.hist_valid    = hv;
    bus.hist          = HB'(h);
    bus.resolve_valid = rv;
    bus.resolve_taken = rt;
    bus.flush         = fl;
    if (hv) begin
      e.rdy = model_ready;
      e.ctr = model_ready ? mtab[h] : 0;
      e.h   = h;
      sb.push_back(e);
    end
    @(posedge clock);
    if (model_ready) begin
      if (rv && ent_v.exists(cyc - LAT) && ent_v[cyc - LAT]) begin
        int t;
        t = ent_i[cyc - LAT];
        if (rt) mtab[t] = (mtab[t] < CMAX) ? mtab[t] + 1 : CMAX;
        else    mtab[t] = (mtab[t] > 0) ? mtab[t] - 1 : 0;
      end
      if (fl) begin
        ent_v.delete();
      end else begin
        ent_v[cyc] = hv;
        ent_i[cyc] = h;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic doReset(int n);
    int k;
    exp_t e;
    bus.hist_valid    = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
    bus.flush         = 1'b0;
    bus.hist          = '0;
    reset             = 1'b0;
    model_ready       = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("ready_after_reset_edge", bus.ready, 0);
    for (int i = 1; i < n; i++) begin
      bus.hist_valid    = 1'b1;
      bus.hist          = HB'($urandom_range(0, DEPTH - 1));
      bus.resolve_valid = 1'b1;
      bus.resolve_taken = 1'b1;
      bus.flush         = 1'($urandom_range(0, 1));
      e.rdy = 1'b0;
      e.ctr = 0;
      e.h   = int'(bus.hist);
      sb.push_back(e);
      @(posedge clock);
      #1;
    end
    bus.hist_valid = 1'b0;
    reset          = 1'b1;
    for (k = 1; k <= 1100; k++) begin
      bus.resolve_valid = 1'($urandom_range(0, 1));
      bus.resolve_taken = 1'($urandom_range(0, 1));
      bus.flush         = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
      if (bus.ready === 1'b1) break;
    end
    checkOutput("init_cycles", k, 1024);
    bus.resolve_valid = 1'b0;
    bus.flush         = 1'b0;
    foreach (mtab[i]) mtab[i] = WEAK;
    ent_v.delete();
    model_ready = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    doReset(3);

    applyStimulus(1, 'h155, 0, 0, 0);
    applyStimulus(1, 'h000, 0, 0, 0);
    applyStimulus(1, 'h3FF, 0, 0, 0);

    // Taken training saturates at the top.
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1, 'h155, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(1, 'h155, 1, 1, 0);
    end
    applyStimulus(1, 'h155, 0, 0, 0);

    for (int r = 0; r < 3; r++) begin
      applyStimulus(1, 'h0AA, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(1, 'h0AA, 1, 0, 0);
    end
    applyStimulus(1, 'h0AA, 0, 0, 0);

    // Flush squashes younger lookups but the same-cycle resolve still trains 0x001.
    applyStimulus(1, 'h001, 0, 0, 0);
    applyStimulus(1, 'h010, 0, 0, 0);
    applyStimulus(1, 'h020, 1, 1, 1);
    for (int r = 0; r < 3; r++) applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(1, 'h001, 0, 0, 0);
    applyStimulus(1, 'h010, 0, 0, 0);
    applyStimulus(1, 'h020, 0, 0, 0);

    for (int r = 0; r < 3; r++) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(1, 'h000, 0, 0, 0);

    for (int r = 0; r < 400; r++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0),
                    $urandom_range(0, 7) * 37,
                    1'($urandom_range(0, 4) < 3),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 19) == 0));
    end

    for (int r = 0; r < 3; r++) begin
      applyStimulus(1, 'h155, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(1, 'h155, 1, 1, 0);
    end
    applyStimulus(1, 'h155, 0, 0, 0);
    doReset(2);
    applyStimulus(1, 'h155, 0, 0, 0);
    applyStimulus(1, 'h3FF, 0, 0, 0);

    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("sb_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
